// File: rtl/cdf_map_reader.sv
// Reads the finished CDF table back from SRAM bin by bin and streams the
// equalized intensity of each bin to the pixel-remap stage over valid/ready.
module cdf_map_reader #(
    parameter int NUM_BINS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int MAP_W       = 8,
    parameter int LOG2_PIXELS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_bin,
    output logic [MAP_W-1:0]  out_map
);

    localparam int                PROD_W    = DATA_W + MAP_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
    localparam logic [MAP_W-1:0]  MAP_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_inFlight;
    logic [ADDR_W-1:0] r_flightAddr;
    logic [ADDR_W-1:0] r_fifoBin [2];
    logic [MAP_W-1:0]  r_fifoMap [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_lastIssue;
    logic [1:0]        w_committed;
    logic [1:0]        w_countNext;
    logic [PROD_W-1:0] w_product;
    logic [PROD_W-1:0] w_scaled;
    logic [MAP_W-1:0]  w_map;

    assign w_pop  = (r_count != 2'd0) && out_ready;
    assign w_push = r_inFlight;

    // Slots already spoken for once this cycle's pop leaves; counting the pop
    // lets a new read go out every cycle while the consumer keeps up.
    assign w_committed = r_count - {1'b0, w_pop} + {1'b0, r_inFlight};
    assign w_issue     = (r_state == READ) && (w_committed < 2'd2);
    assign w_lastIssue = w_issue && (r_rdAddr == LAST_ADDR);
    assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign w_product = {{MAP_W{1'b0}}, mem_rdata} * {{DATA_W{1'b0}}, MAP_MAX};
    assign w_scaled  = w_product >> LOG2_PIXELS;
    assign w_map     = (w_scaled > PROD_W'(MAP_MAX)) ? MAP_MAX : w_scaled[MAP_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rdAddr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= READ;
                        r_rdAddr <= '0;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_rdAddr <= r_rdAddr + 1'b1;
                    end
                    if (w_lastIssue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as soon as the final beat is being accepted.
                    if (w_countNext == 2'd0) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inFlight   <= 1'b0;
            r_flightAddr <= '0;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoBin[i] <= '0;
                r_fifoMap[i] <= '0;
            end
        end else begin
            r_inFlight <= w_issue;
            if (w_issue) begin
                r_flightAddr <= r_rdAddr;
            end
            if (w_push) begin
                r_fifoBin[r_wrPtr] <= r_flightAddr;
                r_fifoMap[r_wrPtr] <= w_map;
                r_wrPtr            <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= w_countNext;
        end
    end

    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? r_rdAddr : '0;
    assign out_valid = (r_count != 2'd0);
    assign out_bin   = r_fifoBin[r_rdPtr];
    assign out_map   = r_fifoMap[r_rdPtr];
    assign done      = (r_state == FINISH);
    // busy rises in the very cycle start is sampled, but never while reset holds.
    assign busy      = reset && ((r_state == READ) || (r_state == DRAIN) ||
                                 ((r_state == IDLE) && start));

endmodule

// File: tb/tb_cdf_map_reader.sv
// Randomized bench for cdf_map_reader: an SRAM model feeds the DUT and a
// scoreboard checks every accepted beat against arithmetic on the SRAM contents.
module tb_cdf_map_reader;

    localparam int NUM_BINS    = 32;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 16;
    localparam int MAP_W       = 8;
    localparam int LOG2_PIXELS = 12;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_bin;
    logic [MAP_W-1:0]  out_map;

    logic [DATA_W-1:0] sram [NUM_BINS];

    int total = 0;
    int bad   = 0;

    int expBin    = 0;
    int issued    = 0;
    int accepted  = 0;
    int doneCount = 0;
    bit prevHold  = 0;
    logic [ADDR_W-1:0] holdBin;
    logic [MAP_W-1:0]  holdMap;

    cdf_map_reader #(
        .NUM_BINS   (NUM_BINS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAP_W      (MAP_W),
        .LOG2_PIXELS(LOG2_PIXELS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bin  (out_bin),
        .out_map  (out_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    // Equalized value straight from the mapping formula, saturated
    function automatic int refMap(input int cdfVal);
        longint scaled;
        scaled = (longint'(cdfVal) * ((1 << MAP_W) - 1)) >> LOG2_PIXELS;
        if (scaled > (1 << MAP_W) - 1) scaled = (1 << MAP_W) - 1;
        return int'(scaled);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Scoreboard: sees each cycle's handshake at the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            expBin   = 0;
            issued   = 0;
            accepted = 0;
            prevHold = 0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_bin", out_bin, holdBin);
                checkOutput("hold_map", out_map, holdMap);
            end
            if (out_valid && out_ready) begin
                checkOutput("bin_order", out_bin, expBin);
                if (expBin < NUM_BINS) checkOutput("map_value", out_map, refMap(sram[expBin]));
                expBin++;
                accepted++;
            end
            if (mem_rd_en) begin
                issued++;
                checkOutput("no_overflow", (issued - accepted) <= 2, 1);
            end
            prevHold = out_valid && !out_ready;
            holdBin  = out_bin;
            holdMap  = out_map;
            if (done) begin
                doneCount++;
                checkOutput("bins_at_done", expBin, NUM_BINS);
                expBin   = 0;
                issued   = 0;
                accepted = 0;
            end
        end
    end

    // One full readout. Leaves start high after done when chainStart is set.
    task automatic applyStimulus(input int readyPct, input int stallBin,
                                 input bit midStart, input bit chainStart);
        int k, firstValid, doneAt, stallLeft, donesBefore;
        donesBefore = doneCount;
        firstValid  = -1;
        doneAt      = -1;
        stallLeft   = 10;
        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        #1;
        checkOutput("busy_on_start", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 3000 && doneAt < 0; c++) begin
            if (out_valid && out_bin == stallBin && stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = ($urandom_range(99) < readyPct);
            end
            start = (midStart && k == 5);
            @(posedge clk);
            k++;
            #1;
            if (k == 1) checkOutput("busy_in_read", busy, 1);
            if (out_valid && firstValid < 0) firstValid = k;
            if (done) doneAt = k;
        end
        start = 1'b0;
        checkOutput("done_seen", doneAt >= 0, 1);
        if (readyPct == 100 && stallBin < 0) begin
            checkOutput("first_valid_latency", firstValid, 2);
            checkOutput("done_latency", doneAt, NUM_BINS + 2);
        end
        checkOutput("busy_in_done", busy, 0);
        if (chainStart) begin
            start = 1'b1;
            #1;
            checkOutput("busy_start_in_done", busy, 0);
            @(posedge clk);
            #1;
            checkOutput("done_one_cycle", done, 0);
            checkOutput("one_done", doneCount - donesBefore, 1);
        end else begin
            @(negedge clk);
            #1;
            checkOutput("one_done", doneCount - donesBefore, 1);
            @(posedge clk);
            #1;
            checkOutput("done_one_cycle", done, 0);
            checkOutput("idle_busy", busy, 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
        checkOutput({tag, "_addr"}, mem_addr, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_bin"}, out_bin, 0);
        checkOutput({tag, "_map"}, out_map, 0);
    endtask

    // Stall on bin 12, then pull reset asynchronously between clock edges
    task automatic resetMidStall();
        int donesBefore;
        bit reached;
        reached = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid && out_bin == 12) reached = 1;
        end
        out_ready = 1'b0;
        checkOutput("reached_bin12", reached, 1);
        repeat (3) @(posedge clk);
        #2;
        donesBefore = doneCount;
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        for (int c = 0; c < 4; c++) begin
            start = c[0];
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checkAllZero("held_reset");
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("no_done_after_abort", doneCount - donesBefore, 0);
        checkOutput("idle_after_abort", busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d checks expected completion", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < NUM_BINS; i++) sram[i] = DATA_W'((i + 1) * 128);

        // Reset held while start pulses
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = ~start;
            #1;
            checkAllZero("reset");
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] linear CDF, full throughput");
        applyStimulus(100, -1, 0, 0);

        $display("[TB] random CDF with saturating bin 5, random backpressure, stall at bin 10, extra start");
        for (int i = 0; i < NUM_BINS; i++) sram[i] = DATA_W'($urandom_range(0, 65535));
        sram[5] = 16'hFFFF;
        applyStimulus(60, 10, 1, 0);

        $display("[TB] start in done cycle ignored, start next cycle runs again");
        for (int i = 0; i < NUM_BINS; i++) sram[i] = DATA_W'($urandom_range(0, 8191));
        applyStimulus(100, -1, 0, 1);
        applyStimulus(70, -1, 0, 0);

        $display("[TB] reset during stall at bin 12");
        resetMidStall();
        for (int i = 0; i < NUM_BINS; i++) sram[i] = DATA_W'($urandom_range(0, 65535));
        applyStimulus(50, -1, 0, 0);
        applyStimulus(100, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
